// File: rtl/bipad_ctrl.sv
// Core-side controller for one bidirectional pad: dead-time direction turnaround
// on the output side, synchronizer plus debounce filter with edge pulses on the input side.
module bipad_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned TURN        = 2,
   parameter logic        INIT        = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic PAD_Q,
   input  logic A,
   input  logic OE_REQ,
   output logic PAD_A,
   output logic PAD_EN,
   output logic OE_ACK,
   output logic Q,
   output logic RISE,
   output logic FALL
);

   localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int unsigned TC_W = (TURN > 1) ? $clog2(TURN) : 1;

   localparam logic [1:0] ST_IN    = 2'd0;
   localparam logic [1:0] ST_T_OUT = 2'd1;
   localparam logic [1:0] ST_OUT   = 2'd2;
   localparam logic [1:0] ST_T_IN  = 2'd3;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   q_q, q_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [1:0]             state_q, state_d;
   logic [TC_W-1:0]        turn_cnt_q, turn_cnt_d;
   logic                   pad_a_q, pad_a_d;
   logic                   pad_en_q, pad_en_d;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Input path: shift the pad into the synchronizer, accept a new level only
   // after DEBOUNCE consecutive samples disagree with the current level.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], PAD_Q};
      db_cnt_d = '0;
      q_d      = q_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      if (sync_s != q_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
            q_d    = sync_s;
            rise_d = sync_s;
            fall_d = ~sync_s;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   // Direction FSM: every change of direction spends TURN cycles with the pad released.
   always_comb begin
      state_d    = state_q;
      turn_cnt_d = turn_cnt_q;
      case (state_q)
         ST_IN: begin
            if (OE_REQ) begin
               state_d    = ST_T_OUT;
               turn_cnt_d = '0;
            end
         end
         ST_T_OUT: begin
            turn_cnt_d = turn_cnt_q + TC_W'(1);
            if (!OE_REQ) begin
               state_d = ST_IN;
            end else if (turn_cnt_q == TC_W'(TURN - 1)) begin
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (!OE_REQ) begin
               state_d    = ST_T_IN;
               turn_cnt_d = '0;
            end
         end
         ST_T_IN: begin
            turn_cnt_d = turn_cnt_q + TC_W'(1);
            if (turn_cnt_q == TC_W'(TURN - 1)) begin
               state_d = ST_IN;
            end
         end
         default: begin
            state_d    = ST_IN;
            turn_cnt_d = '0;
         end
      endcase
   end

   // Enable is a flop of "was in OUT", so it drops on the cycle after leaving OUT.
   always_comb begin
      pad_a_d  = A;
      pad_en_d = (state_q == ST_OUT);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_q     <= {SYNC_STAGES{INIT}};
         db_cnt_q   <= '0;
         q_q        <= INIT;
         rise_q     <= 1'b0;
         fall_q     <= 1'b0;
         state_q    <= ST_IN;
         turn_cnt_q <= '0;
         pad_a_q    <= 1'b0;
         pad_en_q   <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         db_cnt_q   <= db_cnt_d;
         q_q        <= q_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         state_q    <= state_d;
         turn_cnt_q <= turn_cnt_d;
         pad_a_q    <= pad_a_d;
         pad_en_q   <= pad_en_d;
      end
   end

   assign PAD_A  = pad_a_q;
   assign PAD_EN = pad_en_q;
   assign OE_ACK = pad_en_q;
   assign Q      = q_q;
   assign RISE   = rise_q;
   assign FALL   = fall_q;

endmodule

// File: tb/tb_bipad_ctrl.sv
// Bench for bipad_ctrl: directed scenarios plus random traffic, checked every cycle
// against a sample-history / run-length reference model.
module tb_bipad_ctrl;

   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned DEBOUNCE    = 4;
   localparam int unsigned TURN        = 2;
   localparam logic        INIT        = 1'b0;

   logic clk = 1'b0;
   logic rst, pad_q, a, oe_req;
   logic pad_a, pad_en, oe_ack, q, rise, fall;

   bipad_ctrl #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE),
      .TURN       (TURN),
      .INIT       (INIT)
   ) dut (
      .CLK   (clk),
      .RST   (rst),
      .PAD_Q (pad_q),
      .A     (a),
      .OE_REQ(oe_req),
      .PAD_A (pad_a),
      .PAD_EN(pad_en),
      .OE_ACK(oe_ack),
      .Q     (q),
      .RISE  (rise),
      .FALL  (fall)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          cyc      = 0;

   // Reference model state
   logic pipe_m[$];
   logic s_hist_m[$];
   logic q_m, rise_m, fall_m, pad_a_m, en_m, drive_m;
   int   run_m, ignore_until_m;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Advance the model by one clock edge using the inputs that edge sampled.
   task automatic model_edge();
      logic s, all_diff;
      if (rst) begin
         pipe_m.delete();
         for (int i = 0; i < int'(SYNC_STAGES); i++) pipe_m.push_back(INIT);
         s_hist_m.delete();
         q_m = INIT; rise_m = 1'b0; fall_m = 1'b0;
         pad_a_m = 1'b0; en_m = 1'b0; drive_m = 1'b0;
         run_m = 0; ignore_until_m = -1;
      end else begin
         s = pipe_m.pop_front();
         pipe_m.push_back(pad_q);
         s_hist_m.push_back(s);
         if (s_hist_m.size() > int'(DEBOUNCE)) void'(s_hist_m.pop_front());
         rise_m = 1'b0;
         fall_m = 1'b0;
         if (s_hist_m.size() == int'(DEBOUNCE)) begin
            all_diff = 1'b1;
            foreach (s_hist_m[i]) if (s_hist_m[i] == q_m) all_diff = 1'b0;
            if (all_diff) begin
               q_m    = s;
               rise_m = s;
               fall_m = ~s;
            end
         end
         pad_a_m = a;
         en_m    = drive_m;
         // Driving needs TURN+1 consecutive request samples once idle; a release
         // makes the request invisible for the following TURN edges.
         if (drive_m) begin
            if (!oe_req) begin
               drive_m        = 1'b0;
               ignore_until_m = cyc + int'(TURN);
               run_m          = 0;
            end
         end else if (cyc > ignore_until_m) begin
            if (oe_req) begin
               run_m++;
               if (run_m == int'(TURN) + 1) begin
                  drive_m = 1'b1;
                  run_m   = 0;
               end
            end else begin
               run_m = 0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      model_edge();
      check_bit("pad_en", pad_en, en_m);
      check_bit("oe_ack", oe_ack, en_m);
      check_bit("pad_a", pad_a, pad_a_m);
      check_bit("q", q, q_m);
      check_bit("rise", rise, rise_m);
      check_bit("fall", fall, fall_m);
      check_bit("rise_fall_excl", rise & fall, 1'b0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int pad_run, req_run;
      rst = 1'b1; pad_q = 1'b1; a = 1'b0; oe_req = 1'b0;

      // Reset and idle: Q rises exactly SYNC_STAGES+DEBOUNCE edges after release
      steps(3);
      rst = 1'b0;
      steps(5);
      check_bit("plan_q_before_edge6", q, 1'b0);
      step();
      check_bit("plan_q_at_edge6", q, 1'b1);
      check_bit("plan_rise_at_edge6", rise, 1'b1);
      step();
      check_bit("plan_rise_one_cycle", rise, 1'b0);

      // Settle at 0, then a 3-cycle glitch and a 4-cycle pulse
      pad_q = 1'b0; steps(10);
      pad_q = 1'b1; steps(3);
      pad_q = 1'b0; steps(10);
      check_bit("plan_glitch_rejected", q, 1'b0);
      pad_q = 1'b1; steps(4);
      pad_q = 1'b0; steps(12);

      // Turnaround to drive
      a = 1'b1; oe_req = 1'b1;
      steps(3);
      check_bit("plan_en_low_in_turn", pad_en, 1'b0);
      step();
      check_bit("plan_en_high_after_turn", pad_en, 1'b1);
      check_bit("plan_pad_a_driven", pad_a, 1'b1);
      steps(8);

      // Release and immediate re-request
      oe_req = 1'b0; step();
      oe_req = 1'b1; steps(10);

      // Single-cycle request aborts
      oe_req = 1'b0; steps(6);
      oe_req = 1'b1; step();
      oe_req = 1'b0; steps(6);

      // Reset while driving and mid-debounce
      oe_req = 1'b1; steps(8);
      pad_q = 1'b1; steps(4);
      rst = 1'b1; step();
      check_bit("plan_rst_en", pad_en, 1'b0);
      check_bit("plan_rst_q", q, INIT);
      rst = 1'b0; steps(12);

      // Random traffic
      pad_run = 0; req_run = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 199) == 0);
         a   = 1'($urandom);
         if (pad_run == 0) begin
            pad_q   = ~pad_q;
            pad_run = $urandom_range(1, 7);
         end
         if (req_run == 0) begin
            oe_req  = ~oe_req;
            req_run = $urandom_range(1, 12);
         end
         pad_run--;
         req_run--;
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
